// File: rtl/alu.sv
// alu: W-bit ALU with a registered result and registered NZCV flags, one cycle of latency
// Ports: clk, rst (synchronous, active high), I1/I2 operands (I2 is the shift amount),
//        alu_ctr operation select, out registered result, N/Z/C/V_flag registered flags.
// Build option: define ALU_SRA_EN to enable the arithmetic right shift on alu_ctr=1010.
module alu #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] I1,
   input  logic [W-1:0] I2,
   input  logic [3:0]   alu_ctr,
   output logic [W-1:0] out,
   output logic         N_flag,
   output logic         Z_flag,
   output logic         C_flag,
   output logic         V_flag
);
   logic         sub;
   logic [W-1:0] bx;
   logic [W:0]   sum;
   logic [W-1:0] res;
   logic         c;
   logic         v;
   // ADD and SUB share one W+1-bit adder; SUB is I1 + ~I2 + 1, so the carry-out means "no borrow"
   always_comb begin
      sub = alu_ctr == 4'b0011;
      bx  = sub ? ~I2 : I2;
      sum = {1'b0, I1} + {1'b0, bx} + {{W{1'b0}}, sub};
      res = '0;
      c   = 1'b0;
      v   = 1'b0;
      case (alu_ctr)
         4'b0000: res = I1 & I2;
         4'b0001: res = I1 | I2;
         4'b0010, 4'b0011: begin
            res = sum[W-1:0];
            c   = sum[W];
            v   = (I1[W-1] == bx[W-1]) && (sum[W-1] != I1[W-1]);
         end
         4'b0100: res = {{(W-1){1'b0}}, $signed(I1) < $signed(I2)};
         4'b0101: res = I1 << I2;
         4'b0110: res = I1 >> I2;
         4'b0111: res = I1 ^ I2;
         4'b1000: res = ~(I1 | I2);
         4'b1001: res = ~(I1 & I2);
`ifdef ALU_SRA_EN
         4'b1010: res = $signed(I1) >>> I2;
`else
`endif
         default: res = '0;
      endcase
   end
   // Z resets to 0 even though out resets to 0
   always_ff @(posedge clk) begin
      if (rst) begin
         out    <= '0;
         N_flag <= 1'b0;
         Z_flag <= 1'b0;
         C_flag <= 1'b0;
         V_flag <= 1'b0;
      end else begin
         out    <= res;
         N_flag <= res[W-1];
         Z_flag <= res == '0;
         C_flag <= c;
         V_flag <= v;
      end
   end
endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboard bench for alu with directed and randomized vectors against an integer model
module tb_alu;
   localparam int W = 5;
   localparam int M = (1 << W) - 1;
   typedef struct packed {
      logic [W-1:0] o;
      logic n, z, c, v;
   } exp_t;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] I1 = '0;
   logic [W-1:0] I2 = '0;
   logic [3:0]   alu_ctr = '0;
   logic [W-1:0] out;
   logic         N_flag, Z_flag, C_flag, V_flag;
   exp_t         q[$];
   int           tags[$];
   int           vectors = 0;
   int           miscompares = 0;
   alu #(.W(W)) dut (
      .clk(clk), .rst(rst), .I1(I1), .I2(I2), .alu_ctr(alu_ctr),
      .out(out), .N_flag(N_flag), .Z_flag(Z_flag), .C_flag(C_flag), .V_flag(V_flag)
   );
   always #5 clk = ~clk;
   function automatic int sgn(input int x);
      return x >= (1 << (W - 1)) ? x - (1 << W) : x;
   endfunction
   function automatic bit ovf(input int x);
      return x > (1 << (W - 1)) - 1 || x < -(1 << (W - 1));
   endfunction
   function automatic exp_t model(input bit r, input int op, input int a, input int b);
      exp_t e;
      int   res, sa, sb;
      bit   c, v;
      sa = sgn(a); sb = sgn(b); c = 0; v = 0; res = 0;
      case (op)
         0: res = a & b;
         1: res = a | b;
         2: begin res = a + b; c = res > M; v = ovf(sa + sb); end
         3: begin res = a - b; c = a >= b; v = ovf(sa - sb); end
         4: res = sa < sb ? 1 : 0;
         5: res = b >= W ? 0 : a << b;
         6: res = b >= W ? 0 : a >> b;
         7: res = a ^ b;
         8: res = ~(a | b);
         9: res = ~(a & b);
`ifdef ALU_SRA_EN
         10: res = b >= W ? (sa < 0 ? -1 : 0) : sa >>> b;
`endif
         default: res = 0;
      endcase
      res &= M;
      e.o = res[W-1:0];
      e.n = res[W-1];
      e.z = res == 0;
      e.c = c;
      e.v = v;
      if (r) e = '0;
      return e;
   endfunction
   task automatic apply(input bit r, input int op, input int a, input int b, input int tag);
      @(negedge clk);
      rst = r; alu_ctr = op[3:0]; I1 = a[W-1:0]; I2 = b[W-1:0];
      q.push_back(model(r, op, a, b));
      tags.push_back(tag);
   endtask
   initial begin
      exp_t e, got;
      int   t;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            t = tags.pop_front();
            got = {out, N_flag, Z_flag, C_flag, V_flag};
            vectors++;
            if (got !== e) begin
               miscompares++;
               $display("FAIL vec%0d: got out=%b NZCV=%b%b%b%b, expected out=%b NZCV=%b%b%b%b",
                        t, got.o, got.n, got.z, got.c, got.v, e.o, e.n, e.z, e.c, e.v);
            end
         end
      end
   end
   initial begin
      apply(1, 0, 7, 9, 0);
      apply(0, 0, 'b10101, 'b11011, 1);
      apply(0, 1, 'b10101, 'b11011, 2);
      apply(0, 7, 'b10101, 'b11011, 3);
      apply(0, 8, 'b10101, 'b11011, 4);
      apply(0, 9, 'b10101, 'b11011, 5);
      apply(0, 2, 'b00101, 'b00011, 6);
      apply(0, 2, 'b01111, 'b01111, 7);
      apply(0, 3, 'b01010, 'b00011, 8);
      apply(0, 3, 'b10000, 'b00001, 9);
      apply(0, 4, 'b00011, 'b00100, 10);
      apply(0, 4, 'b10000, 'b00001, 11);
      apply(0, 5, 'b00011, 2, 12);
      apply(0, 6, 'b10000, 2, 13);
      apply(0, 6, 'b10000, 6, 14);
      apply(0, 10, 'b10000, 2, 15);
      apply(0, 15, 'b11111, 'b11111, 16);
      apply(0, 3, 'b00000, 'b10000, 17);
      apply(0, 2, 'b11111, 'b00001, 18);
      apply(0, 5, 'b10101, 0, 19);
      apply(1, 2, 'b11111, 'b11111, 20);
      for (int i = 0; i < 400; i++)
         apply($urandom_range(0, 24) == 0, $urandom_range(0, 15),
               $urandom_range(0, M), $urandom_range(0, M), 100 + i);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d results never checked, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/alu.md
# alu

Parameterised W-bit arithmetic/logic unit for the single-cycle RISC-V datapath, with registered result and NZCV flags. Takes two operands and a 4-bit operation code from the ALU control decoder and returns the result one clock later. The branch and condition logic consume the flag outputs.

## Interface
- W, default 5: operand and result width in bits, W ≥ 2.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- I1  input  W  operand A.
- I2  input  W  operand B; for shifts, the shift amount.
- alu_ctr  input  4  operation select.
- out  output  W  registered result.
- N_flag  output  1  registered negative flag.
- Z_flag  output  1  registered zero flag.
- C_flag  output  1  registered carry flag.
- V_flag  output  1  registered signed-overflow flag.

## Operation
- alu_ctr encoding:
  - 0000 AND
  - 0001 OR
  - 0010 ADD (I1+I2)
  - 0011 SUB (I1−I2)
  - 0100 SLT: result 1 if I1 < I2, signed two's complement, else 0
  - 0101 SLL: I1 << I2
  - 0110 SRL: I1 >> I2, logical
  - 0111 XOR
  - 1000 NOR
  - 1001 NAND
  - 1010 SRA: only with ALU_SRA_EN
- Any other code gives a result of 0, and C and V are 0.
- Arithmetic width rules:
  - ADD computes {C, result} = I1 + I2 over W+1 bits.
  - SUB computes I1 + ~I2 + 1 over W+1 bits. C is the carry-out, so C=1 means no borrow (I1 ≥ I2 unsigned).
  - V=1 when both operands of ADD (or I1 and ~I2 for SUB) share a sign bit that differs from the result's sign bit.
- C and V are 0 for every operation other than ADD and SUB.
- Shifts:
  - The amount is I2 as an unsigned value.
  - An amount ≥ W gives 0 for SLL and SRL, and all copies of I1[W-1] for SRA.
  - An amount of 0 passes I1 through unchanged.
- N = result[W-1] and Z = (result == 0) for all operations, including SLT and undefined codes.

## Timing
- Inputs are sampled on each rising edge of clk. out and the flags update on that edge: latency 1 cycle, throughput 1 operation per cycle.
- There is no handshake. The outputs hold their value until the next edge.
- If rst=1 at an edge, out=0 and N=Z=C=V=0 after that edge. Inputs are ignored on that edge.
- Reset has priority over any operation and may arrive mid-stream. The first valid result appears on the edge after rst is deasserted.
- The reset value Z=0 is deliberate; it does not reflect out==0.

## Configuration
- ALU_SRA_EN defined: alu_ctr=1010 performs an arithmetic right shift of I1 by I2, filling with the sign bit.
- ALU_SRA_EN undefined: 1010 behaves as an undefined code (result 0, C=V=0, Z=1).

## Test plan
W=5 throughout; every check is made one edge after the stimulus is applied.
- Reset: assert rst with any inputs -> out=00000 and NZCV=0000. Release rst and apply AND 10101,11011 -> out=10001, N=1.
- Logic ops on I1=10101, I2=11011:
  - OR -> 11111
  - XOR -> 01110
  - NOR -> 00000 with Z=1
  - NAND -> 01110
- ADD:
  - 00101+00011 -> 01000, C=0, V=0.
  - 01111+01111 -> 11110, N=1, V=1, C=0.
- SUB:
  - 01010−00011 -> 00111, C=1, V=0.
  - 10000−00001 -> 01111, V=1, C=1, N=0.
- SLT and shifts:
  - SLT 00011 vs 00100 -> 00001.
  - SLT 10000 vs 00001 -> 00001, signed.
  - SLL 00011 by 2 -> 01100.
  - SRL 10000 by 2 -> 00100.
  - SRL by 6 -> 00000, Z=1.
- Config and undefined codes:
  - With ALU_SRA_EN, SRA 10000 by 2 -> 11100.
  - Without ALU_SRA_EN, alu_ctr=1010 -> 00000, Z=1.
  - alu_ctr=1111 -> 00000, Z=1, C=V=0.
